// File: rtl/down_seq.sv
// down_seq: narrows one DIN_W source transfer (byte/word/long/phrase) into DOUT_W beats.
// Define DOWN_SEQ_REPL_EN to replicate sub-beat items across every lane instead of zero-filling.
module down_seq #(
    parameter int unsigned DIN_W  = 64,
    parameter int unsigned DOUT_W = 32
) (
    input  logic                       sys_clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIN_W-1:0]           din,
    input  logic [1:0]                 in_siz,
    input  logic [$clog2(DIN_W/8)-1:0] in_off,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DOUT_W-1:0]          dout,
    output logic                       out_last,
    output logic                       busy
);

    localparam int unsigned OFF_W = $clog2(DIN_W / 8);
    localparam int unsigned CNT_W = $clog2(DIN_W / DOUT_W);

    typedef enum logic {
        StIdle,
        StSend
    } state_t;

    state_t             state_q;
    logic [DIN_W-1:0]   data_q;
    logic [1:0]         siz_q;
    logic [OFF_W-1:0]   off_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OFF_W-1:0]   in_off_aligned;
    logic               accept;
    logic               beat_hs;

    function automatic int unsigned size_bits(input logic [1:0] siz);
        int unsigned bits;
        case (siz)
            2'd0:    bits = 8;
            2'd1:    bits = 16;
            2'd2:    bits = 32;
            default: bits = DIN_W;
        endcase
        return bits;
    endfunction

    // Phrase transfers have an all-ones mask, so their offset always collapses to 0.
    function automatic logic [OFF_W-1:0] align_off(input logic [1:0] siz,
                                                   input logic [OFF_W-1:0] off);
        logic [OFF_W-1:0] mask;
        mask = OFF_W'(size_bits(siz) / 8 - 1);
        return off & ~mask;
    endfunction

    function automatic logic is_last(input logic [1:0] siz, input logic [CNT_W-1:0] k);
        int unsigned n;
        n = (size_bits(siz) > DOUT_W) ? size_bits(siz) / DOUT_W : 1;
        return k == CNT_W'(n - 1);
    endfunction

    function automatic logic [DOUT_W-1:0] beat_of(input logic [DIN_W-1:0] data,
                                                  input logic [1:0]       siz,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic [CNT_W-1:0] k);
        int unsigned       sbits;
        int unsigned       base;
        logic [DOUT_W-1:0] item;
        logic [DOUT_W-1:0] res;
        sbits = size_bits(siz);
        base  = 32'(off) * 8;
        res   = '0;
        if (sbits >= DOUT_W) begin
            res = DOUT_W'(data >> (base + 32'(k) * DOUT_W));
        end else begin
            item = DOUT_W'(data >> base) & ({DOUT_W{1'b1}} >> (DOUT_W - sbits));
`ifdef DOWN_SEQ_REPL_EN
            for (int unsigned j = 0; j < DOUT_W / 8; j++) begin
                if (j * sbits < DOUT_W) begin
                    res = res | (item << (j * sbits));
                end
            end
`else
            // Keep the item at its byte lane inside the DOUT_W chunk that holds it.
            res = item << (base % DOUT_W);
`endif
        end
        return res;
    endfunction

    always_comb begin
        in_off_aligned = align_off(in_siz, in_off);
        beat_hs        = out_valid && out_ready;
        in_ready       = !reset && ((state_q == StIdle) || (beat_hs && out_last));
        accept         = in_valid && in_ready;
        busy           = (state_q != StIdle);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            data_q    <= '0;
            siz_q     <= '0;
            off_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            dout      <= '0;
        end else if (accept) begin
            // Covers both a fresh start from idle and a bubble-free follow-on after the last beat.
            state_q   <= StSend;
            data_q    <= din;
            siz_q     <= in_siz;
            off_q     <= in_off_aligned;
            cnt_q     <= '0;
            out_valid <= 1'b1;
            out_last  <= is_last(in_siz, '0);
            dout      <= beat_of(din, in_siz, in_off_aligned, '0);
        end else if (beat_hs) begin
            if (out_last) begin
                state_q   <= StIdle;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                cnt_q    <= cnt_q + 1'b1;
                out_last <= is_last(siz_q, cnt_q + 1'b1);
                dout     <= beat_of(data_q, siz_q, off_q, cnt_q + 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_down_seq.sv
// Scoreboard bench for down_seq: directed corner cases, then randomized transfers against a
// byte-level reference model, with a separate monitor checking every output beat.
module tb_down_seq;

    localparam int unsigned DIN_W  = 64;
    localparam int unsigned DOUT_W = 32;
    localparam int unsigned OFF_W  = $clog2(DIN_W / 8);

`ifdef DOWN_SEQ_REPL_EN
    localparam logic [DOUT_W-1:0] EXP_BYTE = 32'h33333333;
    localparam logic [DOUT_W-1:0] EXP_WORD = 32'h11221122;
`else
    localparam logic [DOUT_W-1:0] EXP_BYTE = 32'h00003300;
    localparam logic [DOUT_W-1:0] EXP_WORD = 32'h11220000;
`endif
    localparam logic [DIN_W-1:0] D0 = 64'h1122334455667788;
    localparam logic [DIN_W-1:0] D1 = 64'hAABBCCDDEEFF0011;

    logic              sys_clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DIN_W-1:0]  din;
    logic [1:0]        in_siz;
    logic [OFF_W-1:0]  in_off;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] dout;
    logic              out_last;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    bit rand_rdy = 0;
    logic [DOUT_W:0] exp_q[$];

    down_seq #(
        .DIN_W (DIN_W),
        .DOUT_W(DOUT_W)
    ) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .in_siz   (in_siz),
        .in_off   (in_off),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .out_last (out_last),
        .busy     (busy)
    );

    initial begin
        sys_clk = 0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: item of S bytes at an offset rounded down to a multiple of S, cut into beats.
    task automatic push_model(input logic [DIN_W-1:0] d, input int siz, input int off);
        int sb;
        int aoff;
        int n;
        logic [DIN_W-1:0]  item;
        logic [DOUT_W-1:0] b;
        sb   = (siz == 3) ? DIN_W / 8 : (1 << siz);
        aoff = (siz == 3) ? 0 : (off / sb) * sb;
        if (sb * 8 >= DOUT_W) begin
            n = sb * 8 / DOUT_W;
            for (int k = 0; k < n; k++) begin
                b = DOUT_W'(d >> (aoff * 8 + k * DOUT_W));
                exp_q.push_back({(k == n - 1), b});
            end
        end else begin
            item = (d >> (aoff * 8)) & ((DIN_W'(1) << (sb * 8)) - 1);
            b = '0;
`ifdef DOWN_SEQ_REPL_EN
            for (int j = 0; j < DOUT_W / (sb * 8); j++) b = b | DOUT_W'(item << (j * sb * 8));
`else
            b = DOUT_W'(item << ((aoff % (DOUT_W / 8)) * 8));
`endif
            exp_q.push_back({1'b1, b});
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic drive_tx(input logic [DIN_W-1:0] d, input logic [1:0] siz,
                            input logic [OFF_W-1:0] off, input bit use_model);
        bit ok;
        ok = 0;
        in_valid = 1;
        din      = d;
        in_siz   = siz;
        in_off   = off;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        end else if (use_model) begin
            push_model(d, int'(siz), int'(off));
        end
        @(posedge sys_clk);
        #1;
        in_valid = 0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL drain_timeout: %0d beats still expected, busy=%0b", exp_q.size(), busy);
        end
        @(posedge sys_clk);
        #1;
    endtask

    // Randomized sink backpressure.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every beat handshake and checks stability under stall.
    initial begin
        logic [DOUT_W:0]   e;
        bit                held;
        logic [DOUT_W-1:0] held_d;
        logic              held_l;
        held = 0;
        forever begin
            @(negedge sys_clk);
            if (!reset && out_valid) begin
                if (held) begin
                    chk("stall_dout", dout, held_d);
                    chk("stall_last", out_last, held_l);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: dout %h with nothing expected", dout);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_dout", dout, e[DOUT_W-1:0]);
                        chk("beat_last", out_last, e[DOUT_W]);
                    end
                    if (out_last) chk("last_in_ready", in_ready, 1);
                    held = 0;
                end else begin
                    held   = 1;
                    held_d = dout;
                    held_l = out_last;
                end
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1;
        in_valid  = 0;
        din       = '0;
        in_siz    = '0;
        in_off    = '0;
        out_ready = 1;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        @(posedge sys_clk);
        #1;
        reset = 0;
        @(negedge sys_clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge sys_clk);
        #1;

        // Phrase, byte, misaligned word.
        exp_q.push_back({1'b0, 32'h55667788});
        exp_q.push_back({1'b1, 32'h11223344});
        drive_tx(D0, 2'd3, 3'd0, 0);
        wait_idle();
        exp_q.push_back({1'b1, EXP_BYTE});
        drive_tx(D0, 2'd0, 3'd5, 0);
        wait_idle();
        exp_q.push_back({1'b1, EXP_WORD});
        drive_tx(D0, 2'd1, 3'd7, 0);
        wait_idle();

        // Backpressure on beat 0.
        out_ready = 0;
        exp_q.push_back({1'b0, 32'h55667788});
        exp_q.push_back({1'b1, 32'h11223344});
        drive_tx(D0, 2'd3, 3'd0, 0);
        repeat (3) begin
            @(negedge sys_clk);
            chk("bp_dout", dout, 32'h55667788);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_last", out_last, 0);
        end
        @(posedge sys_clk);
        #1;
        out_ready = 1;
        wait_idle();

        // Back-to-back phrases: four beats in consecutive cycles.
        exp_q.push_back({1'b0, 32'h55667788});
        exp_q.push_back({1'b1, 32'h11223344});
        exp_q.push_back({1'b0, 32'hEEFF0011});
        exp_q.push_back({1'b1, 32'hAABBCCDD});
        fork
            begin
                drive_tx(D0, 2'd3, 3'd0, 0);
                drive_tx(D1, 2'd3, 3'd0, 0);
            end
            begin
                int t;
                t = 0;
                do begin
                    @(negedge sys_clk);
                    t++;
                end while (!out_valid && t < 50);
                for (int j = 0; j < 4; j++) begin
                    chk("b2b_valid", out_valid, 1);
                    chk("b2b_last", out_last, (j % 2 == 1));
                    if (j < 3) @(negedge sys_clk);
                end
            end
        join
        wait_idle();

        // Reset during beat 0: the rest of that transfer must vanish.
        out_ready = 0;
        drive_tx(D0, 2'd3, 3'd0, 0);
        @(negedge sys_clk);
        chk("mid_valid", out_valid, 1);
        chk("mid_dout", dout, 32'h55667788);
        @(posedge sys_clk);
        #1;
        reset     = 1;
        out_ready = 1;
        @(negedge sys_clk);
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge sys_clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge sys_clk);
        #1;
        reset = 0;
        @(negedge sys_clk);
        chk("mid_post_in_ready", in_ready, 1);
        repeat (3) begin
            @(negedge sys_clk);
            chk("mid_no_beat", out_valid, 0);
        end
        @(posedge sys_clk);
        #1;

        // Randomized traffic with random sink stalls.
        rand_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            logic [DIN_W-1:0] d;
            d = {$urandom(), $urandom()};
            repeat ($urandom_range(0, 2)) begin
                @(posedge sys_clk);
                #1;
            end
            drive_tx(d, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1);
        end
        wait_idle();
        rand_rdy  = 0;
        out_ready = 1;
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/down_seq.md
DOWN_SEQ -- requirements
Module: down_seq

Interface
REQ-001 SHALL provide parameter DIN_W, default 64, source bus width in bits; a power of 2, 32..256.
REQ-002 SHALL provide parameter DOUT_W, default 32, destination bus width in bits; a power of 2, at least 16, and DIN_W/DOUT_W (R) in 2..8.
REQ-003 SHALL provide port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port in_valid, input, 1 bit: the source transfer is valid.
REQ-006 SHALL provide port in_ready, output, 1 bit: the block accepts a transfer.
REQ-007 SHALL provide port din, input, DIN_W bits: the source phrase.
REQ-008 SHALL provide port in_siz, input, 2 bits: 0 = byte (8), 1 = word (16), 2 = long (32), 3 = phrase (DIN_W).
REQ-009 SHALL provide port in_off, input, log2(DIN_W/8) bits: byte offset of the item within din.
REQ-010 SHALL provide port out_valid, output, 1 bit: dout is valid.
REQ-011 SHALL provide port out_ready, input, 1 bit: the sink accepts the beat.
REQ-012 SHALL provide port dout, output, DOUT_W bits: the narrowed beat.
REQ-013 SHALL provide port out_last, output, 1 bit: the final beat of the transfer.
REQ-014 SHALL provide port busy, output, 1 bit: the state is not IDLE.

Function
REQ-015 SHALL define item size S in bits from in_siz, and beat count N = max(1, S/DOUT_W).
REQ-016 SHALL clear the low log2(S/8) bits of in_off before use, so the offset is forced to be size-aligned; in_off SHALL be ignored for phrase transfers.
REQ-017 SHALL implement two states: IDLE and SEND.
REQ-018 SHALL drive in_ready = 1 in IDLE, or in SEND when the last beat handshakes in the same cycle; in_ready SHALL be 0 otherwise and 0 while reset is high.
REQ-019 SHALL, on an in_valid and in_ready handshake, register din, in_siz and the aligned offset, clear the beat counter, and enter or remain in SEND.
REQ-020 SHALL drive out_valid = 1 in SEND, with the first beat one cycle after acceptance.
REQ-021 SHALL, when S >= DOUT_W, drive beat k as dout = held din[off*8 + k*DOUT_W +: DOUT_W], for k = 0..N-1 in ascending order.
REQ-022 SHALL, when S < DOUT_W, send a single beat whose content is defined by REQ-034/REQ-035.
REQ-023 SHALL assert out_last on beat N-1 only.
REQ-024 SHALL advance the beat counter only on an out_valid and out_ready handshake.
REQ-025 SHALL hold dout and out_last stable while out_valid = 1 and out_ready = 0.
REQ-026 SHALL, on the last-beat handshake, go to IDLE if no new transfer is accepted; a simultaneous new acceptance SHALL go to SEND at beat 0, with no bubble.
REQ-027 SHALL ignore in_valid while in SEND and not on the last-beat handshake.
REQ-028 SHALL hold dout at its last value in IDLE, with out_valid = 0 and out_last = 0.

Reset
REQ-029 SHALL, while reset is high, force state = IDLE, beat counter = 0, out_valid = 0, out_last = 0, dout = 0, busy = 0 and in_ready = 0.
REQ-030 SHALL, when reset is asserted mid-transfer, discard that transfer; no further beats of it SHALL be emitted.
REQ-031 SHALL assert in_ready = 1 in the first cycle after reset deasserts.
REQ-032 SHALL let reset take priority over any simultaneous handshake.

Configuration
REQ-033 SHALL support the macro DOWN_SEQ_REPL_EN.
REQ-034 SHALL, with DOWN_SEQ_REPL_EN defined, replicate a sub-DOUT_W item across all DOUT_W/S lanes of dout.
REQ-035 SHALL, without DOWN_SEQ_REPL_EN, place a sub-DOUT_W item at its byte lane within the DOUT_W chunk that contains it, and drive all other dout bits 0.

Verification
REQ-036 SHALL cover a phrase transfer: siz=3, din=0x1122334455667788, out_ready=1 -> dout 0x55667788 then 0x11223344; out_last on the 2nd beat; in_ready=1 on that cycle.
REQ-037 SHALL cover a byte transfer: siz=0, off=5, same din -> 0x33333333 with DOWN_SEQ_REPL_EN, 0x00003300 without; one beat, out_last=1.
REQ-038 SHALL cover a misaligned word: siz=1, off=7 (treated as 6) -> 0x11221122 with DOWN_SEQ_REPL_EN, 0x11220000 without.
REQ-039 SHALL cover backpressure: out_ready=0 for 3 cycles on beat 0 of a phrase -> dout stays 0x55667788, the counter does not advance, in_ready=0.
REQ-040 SHALL cover back-to-back transfers: two phrases with in_valid held and out_ready=1 -> 4 beats in 4 consecutive cycles, out_last on beats 2 and 4.
REQ-041 SHALL cover reset mid-transfer: reset on beat 0 of a phrase -> next cycle out_valid=0, busy=0, no 0x11223344 beat; in_ready=1 once reset is low.
